// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU writeback stage: data width and frame-tracking states.
package alu_wb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        DONE = 2'd3
    } frame_state_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic synchronous FIFO with asynchronous active-low reset.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module alu_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head,
    output logic                   o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    logic          w_full;

    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = i_pop & (r_count != '0);
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign o_full  = w_full;

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Frames the ALU DATA/VLD stream into tagged 32/64-bit records and queues them for writeback.
// Optional per-width push counters are enabled with the ALU_WB_STATS_EN macro.
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   ACT,
    input  logic                   RDY,
    input  logic [TAG_W-1:0]       TAG_IN,
    input  logic [DATA_W-1:0]      ALU_DATA,
    input  logic                   ALU_VLD,
    output logic                   WB_VLD,
    input  logic                   WB_RDY,
    output logic [TAG_W-1:0]       WB_TAG,
    output logic [DATA_W-1:0]      WB_LO,
    output logic [DATA_W-1:0]      WB_HI,
    output logic                   WB_WIDE,
    output logic                   FULL,
    output logic                   OVF,
    output logic                   FRAME_ERR,
`ifdef ALU_WB_STATS_EN
    output logic [15:0]            STAT_NARROW,
    output logic [15:0]            STAT_WIDE,
`endif
    output logic [$clog2(DEPTH):0] COUNT
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        logic              wide;
    } wb_entry_t;

    frame_state_t      r_state;
    logic [TAG_W-1:0]  r_cur_tag;
    logic [TAG_W-1:0]  r_frame_tag;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;
    logic              r_wide;
    logic              r_ovf;
    logic              r_frame_err;

    wb_entry_t         w_push_entry;
    wb_entry_t         w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_drop;
    logic              w_accept;
    logic [CW-1:0]     w_count;

    // Frame tracking: the tag is latched at the first word so a later issue cannot retag it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_cur_tag   <= '0;
            r_frame_tag <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_wide      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (ACT && RDY) begin
                r_cur_tag <= TAG_IN;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (ALU_VLD) begin
                        r_state     <= W1;
                        r_lo        <= ALU_DATA;
                        r_frame_tag <= r_cur_tag;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                W1: begin
                    if (ALU_VLD) begin
                        r_state <= W2;
                        r_hi    <= ALU_DATA;
                    end else begin
                        r_state <= DONE;
                        r_hi    <= '0;
                        r_wide  <= 1'b0;
                    end
                end
                W2: begin
                    if (ALU_VLD) begin
                        r_frame_err <= 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_wide  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push_entry = '{tag: r_frame_tag, lo: r_lo, hi: r_hi, wide: r_wide};
    assign w_push       = (r_state == DONE);
    assign w_pop        = WB_VLD & WB_RDY;
    assign w_drop       = w_push & w_fifo_full & ~w_pop;
    assign w_accept     = w_push & ~w_drop;

    alu_wb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wb_entry_t))
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head),
        .o_full  (w_fifo_full)
    );

    // Sticky overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else begin
            r_ovf <= r_ovf;
        end
    end

`ifdef ALU_WB_STATS_EN
    logic [15:0] r_stat_narrow;
    logic [15:0] r_stat_wide;

    // Counts accepted records by width; wraps naturally at 16 bits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stat_narrow <= 16'd0;
            r_stat_wide   <= 16'd0;
        end else if (w_accept) begin
            if (r_wide) begin
                r_stat_wide <= r_stat_wide + 16'd1;
            end else begin
                r_stat_narrow <= r_stat_narrow + 16'd1;
            end
        end else begin
            r_stat_narrow <= r_stat_narrow;
            r_stat_wide   <= r_stat_wide;
        end
    end

    assign STAT_NARROW = r_stat_narrow;
    assign STAT_WIDE   = r_stat_wide;
`endif

    // One slot stays reserved for the single operation that may be in flight in the ALU.
    assign COUNT     = w_count;
    assign WB_VLD    = (w_count != '0);
    assign FULL      = (w_count >= CW'(DEPTH - 1));
    assign OVF       = r_ovf;
    assign FRAME_ERR = r_frame_err;
    assign WB_TAG    = w_head.tag;
    assign WB_LO     = w_head.lo;
    assign WB_HI     = w_head.hi;
    assign WB_WIDE   = w_head.wide;

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the ALU. Consumes the ALU's DATA/VLD result stream and frames each operation into one result record.
- A one-cycle VLD run gives a 32-bit result; a two-cycle run gives a 64-bit multiply result, low word first.
- Each record is tagged with the destination tag captured at issue, buffered in a small FIFO, and presented to the register-file write port through a valid/ready handshake.
- Drives FULL back to the issue logic, which gates ACT with it, so results are never lost.

Parameters:
DEPTH, 4, result FIFO entries (power of two, >=2)
TAG_W, 5, destination tag width

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
ACT  input  1  ALU activate, same signal driven to the ALU
RDY  input  1  ALU ready; issue = ACT & RDY
TAG_IN  input  TAG_W  destination tag of the operation being issued
ALU_DATA  input  32  ALU DATA output
ALU_VLD  input  1  ALU VLD output
WB_VLD  output  1  head record valid
WB_RDY  input  1  register file accepts head record
WB_TAG  output  TAG_W  head tag
WB_LO  output  32  head low word
WB_HI  output  32  head high word (0 for 32-bit results)
WB_WIDE  output  1  head is a 64-bit result
FULL  output  1  count >= DEPTH-1; upstream must not issue
OVF  output  1  sticky: a record was dropped
FRAME_ERR  output  1  sticky: VLD run longer than 2 cycles
COUNT  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (RST_N=0, asynchronous): all of the following clear immediately, regardless of CLK.
  - Pointers, COUNT=0, WB_VLD=0, FULL=0, OVF=0, FRAME_ERR=0.
  - WB_TAG, WB_LO, WB_HI and WB_WIDE are 0.
  - Frame state returns to IDLE; cur_tag and frame_tag are 0.
- Reset mid-frame discards the partial record; nothing is pushed.
- Issue capture: at a rising edge where ACT & RDY, cur_tag <= TAG_IN.
- Frame FSM states: IDLE, W1, W2, DONE.
  - IDLE: ALU_VLD=1 → W1; lo <= ALU_DATA, frame_tag <= cur_tag.
  - W1: ALU_VLD=1 → W2, hi <= ALU_DATA; ALU_VLD=0 → DONE with wide=0, hi=0.
  - W2: ALU_VLD=1 → stay in W2, set FRAME_ERR, extra word ignored; ALU_VLD=0 → DONE with wide=1.
  - DONE: pushes {frame_tag, lo, hi, wide} into the FIFO, then → IDLE.
  - DONE with ALU_VLD=1 is impossible from the ALU. If it happens, take the IDLE transition: push and start a new frame in the same cycle.
- Latency: last VLD cycle L → DONE in cycle L+1 → record written at end of L+1 → WB_VLD=1 in cycle L+2 (empty FIFO case).
- An issue in the same cycle as DONE only updates cur_tag. The completing record uses frame_tag, latched at its first word.
- FIFO behaviour:
  - WB_VLD = COUNT!=0; head fields are combinational from the read pointer.
  - Pop on WB_VLD & WB_RDY.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: COUNT unchanged, both allowed even at COUNT==DEPTH.
  - Push at COUNT==DEPTH without a pop: record dropped, OVF=1 until reset.
- FULL is combinational from COUNT. Reserving one slot covers the single in-flight ALU operation, so OVF never fires while upstream honours FULL.
- Pop at COUNT==0 is ignored.

Optional Feature:
- Macro: ALU_WB_STATS_EN.
- Defined:
  - Adds outputs STAT_NARROW[15:0] and STAT_WIDE[15:0], counting records pushed (not dropped) by width.
  - Counters wrap at 0xFFFF→0 and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_wb_pkg:
  - DATA_W=32.
  - frame_state_t enum (IDLE, W1, W2, DONE).
  - Parameterised wb_entry_t struct {tag, lo, hi, wide}; the tag width is passed in, or the struct is defined in the module with TAG_W.
- Sub-module alu_wb_fifo:
  - Generic synchronous FIFO with async active-low reset.
  - Inputs push/pop/data; outputs count/head/full-at-DEPTH.
  - alu_writeback instantiates it and derives FULL, OVF and WB_*.

Test Plan:
- Add, REG_A=5, REG_B=7, TAG_IN=3, WB_RDY=1 → one-cycle VLD; WB_VLD high 2 cycles after VLD falls; WB_TAG=3, WB_LO=12, WB_HI=0, WB_WIDE=0; COUNT back to 0 next cycle.
- Mul 0x00010000*0x00010000, TAG_IN=7 → two-cycle VLD; WB_LO=0, WB_HI=1, WB_WIDE=1, WB_TAG=7.
- WB_RDY=0, DEPTH=4, three back-to-back adds → FULL=1 at COUNT=3. Force a 4th and a 5th issue ignoring FULL → COUNT=4, 5th dropped, OVF=1 and sticky. Drain with WB_RDY=1 → tags appear in issue order.
- COUNT=4 with a completion and WB_RDY=1 in the same cycle → COUNT stays 4, OVF stays 0, head advances.
- Assert RST_N=0 in the second VLD cycle of a mul → all outputs 0 immediately; no record after release; next add completes normally.
- Hold ALU_VLD for 3 cycles with data 0xA, 0xB, 0xC → FRAME_ERR=1; record WB_LO=0xA, WB_HI=0xB, WB_WIDE=1.
